// File: rtl/uart_pkg.sv
// Shared types, default parameters and parity helper for the UART blocks.
// Contents: rx_state_t receiver FSM encoding, DEF_* parameter defaults, calc_parity().
// Data words wider than the real frame are zero-extended before calc_parity().
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int DEF_DATA_BITS     = 8;
    localparam int DEF_OVERSAMPLE    = 16;
    localparam int DEF_CLKS_PER_TICK = 27;
    localparam int MAX_DATA_BITS     = 9;

    // Returns the parity bit a transmitter would send for this data word.
    // Zero padding above the real data bits does not change the result.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-clk tick every CLKS_PER_TICK clks.
// Latency: first tick CLKS_PER_TICK clks after clr or rst; no backpressure, free running.
// Ports: clk, rst (sync, active high), clr (sync restart at 0), tick (one-clk pulse).
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = DEF_CLKS_PER_TICK
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(CLKS_PER_TICK);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampled, LSB-first deserialiser with error flags.
// Latency: Data_Rdy ~ (1.5+DATA_BITS[+1])*OVERSAMPLE*CLKS_PER_TICK + 3 clks after the start edge.
// Backpressure: none; every Data_Rdy pulse must be taken by the downstream FIFO.
// Ports: clk, rst (sync, active high), Serial_In (async line, idle high),
//        Rx_Data/Data_Rdy (word + one-clk strobe), Framing_Err, Parity_Err, Rx_Busy.
// Optional: define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int OVERSAMPLE    = DEF_OVERSAMPLE,
    parameter int CLKS_PER_TICK = DEF_CLKS_PER_TICK
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD  = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Serial_In,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Data_Rdy,
    output logic                 Framing_Err,
    output logic                 Parity_Err,
    output logic                 Rx_Busy
);

    localparam int                   SW       = $clog2(OVERSAMPLE);
    localparam int                   BW       = $clog2(DATA_BITS);
    localparam logic [SW-1:0]        MID_CNT  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0]        END_CNT  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]        LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_nxt;
    logic                 sync1;
    logic                 rx_s;
    logic                 tick;
    logic                 tick_clr;
    logic                 smp;
    logic                 par_bad;
    logic [SW-1:0]        sample_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    // Restarting the tick phase on the start edge puts every later sample
    // point a fixed number of clks after the edge, i.e. in mid-bit.
    baud_tick_gen #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign par_bad = (par_bit != calc_parity(MAX_DATA_BITS'(shreg), PARITY_ODD));
`else
    assign par_bad    = 1'b0;
    assign Parity_Err = 1'b0;
`endif

    assign Rx_Busy = (state != IDLE);

    // Next state; smp marks the sample tick of the current state
    // (half a bit in START to hit mid start bit, a full bit elsewhere).
    always_comb begin
        state_nxt = state;
        tick_clr  = 1'b0;
        smp       = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    tick_clr  = 1'b1;
                end
            end
            START: begin
                smp = tick && (sample_cnt == MID_CNT);
                if (smp) begin
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                smp = tick && (sample_cnt == END_CNT);
                if (smp && bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                smp = tick && (sample_cnt == END_CNT);
                if (smp) begin
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                smp = tick && (sample_cnt == END_CNT);
                if (smp) begin
                    state_nxt = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not look like a new start bit.
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sync1       <= 1'b1;
            rx_s        <= 1'b1;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            Rx_Data     <= '0;
            Data_Rdy    <= 1'b0;
            Framing_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
            Parity_Err  <= 1'b0;
`endif
        end else begin
            sync1    <= Serial_In;
            rx_s     <= sync1;
            state    <= state_nxt;
            Data_Rdy <= 1'b0;

            if (state == IDLE || state == WAIT_HIGH) begin
                sample_cnt <= '0;
                bit_cnt    <= '0;
            end else if (tick) begin
                sample_cnt <= smp ? '0 : sample_cnt + 1'b1;
            end

            // Right shift into the MSB: after DATA_BITS samples the first
            // (least significant) bit sits at bit 0.
            if (smp && state == DATA) begin
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end

`ifdef UART_RX_PARITY_EN
            if (smp && state == PARITY) begin
                par_bit <= rx_s;
            end
`endif

            if (smp && state == STOP) begin
                Framing_Err <= !rx_s;
`ifdef UART_RX_PARITY_EN
                Parity_Err  <= par_bad;
`endif
                if (rx_s && !par_bad) begin
                    Rx_Data  <= shreg;
                    Data_Rdy <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_TICK=4, OVERSAMPLE=16 (64 clks per bit).
// Latency: frames are driven bit-exact; Data_Rdy pulses are logged with their clk index.
// Backpressure: none modelled; every pulse is captured by the monitor.
module tb_uart_rx;

    localparam int CPT      = 4;
    localparam int OS       = 16;
    localparam int BIT_CLKS = CPT * OS;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Mid-stop-bit point after the falling edge of the start bit.
    localparam int LAT_NOM = (FRAME_BITS - 1) * BIT_CLKS + BIT_CLKS / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser = 1'b1;
    logic [7:0] rx_data;
    logic       data_rdy;
    logic       ferr;
    logic       perr;
    logic       busy;

    int         cyc    = 0;
    int         n_tot  = 0;
    int         n_pass = 0;
    int         q_cyc[$];
    logic [7:0] q_dat[$];

    uart_rx #(
        .DATA_BITS    (8),
        .OVERSAMPLE   (OS),
        .CLKS_PER_TICK(CPT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Serial_In  (ser),
        .Rx_Data    (rx_data),
        .Data_Rdy   (data_rdy),
        .Framing_Err(ferr),
        .Parity_Err (perr),
        .Rx_Busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_rdy) begin
            q_cyc.push_back(cyc);
            q_dat.push_back(rx_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] dat_at(input int idx);
        return (idx < q_dat.size()) ? q_dat[idx] : 8'hxx;
    endfunction

    function automatic int cyc_at(input int idx);
        return (idx < q_cyc.size()) ? q_cyc[idx] : -100000;
    endfunction

    task automatic clear_log();
        q_cyc.delete();
        q_dat.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drives the first nper bit periods of a frame, 64 clks each, LSB first.
    // t0 is the clk index at which the line fell for the start bit.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_bit,
                              input int nper, output int t0);
        logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop_bit, par, d, 1'b0};
`else
        bits = {1'b1, stop_bit, d, 1'b0};
        if (par) bits[10] = 1'b1;
`endif
        t0 = 0;
        for (int i = 0; i < nper; i++) begin
            @(posedge clk);
            #1;
            ser = bits[i];
            if (i == 0) t0 = cyc;
            repeat (BIT_CLKS - 1) @(posedge clk);
        end
    endtask

    initial begin
        int t0;
        int t1;
        int lat;

        // Reset state
        idle(3);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_data_rdy", data_rdy, 1'b0);
        check("rst_framing_err", ferr, 1'b0);
        check("rst_parity_err", perr, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Clean frame 0xA5, with latency measured from the start edge
        clear_log();
        send_frame(8'hA5, 1'b0, 1'b1, FRAME_BITS, t0);
        idle(20);
        @(negedge clk);
        check("a5_pulses", q_dat.size(), 1);
        check("a5_data", dat_at(0), 8'hA5);
        check("a5_framing_err", ferr, 1'b0);
        check("a5_busy_after", busy, 1'b0);
        lat = cyc_at(0) - t0;
        n_tot++;
        assert (lat >= LAT_NOM - 4 && lat <= LAT_NOM + 4) n_pass++;
        else $error("FAIL a5_latency observed=%0d expected=%0d+-4", lat, LAT_NOM);

        // 20-clk glitch: false start, back to idle well before 40 clks
        clear_log();
        @(posedge clk);
        #1 ser = 1'b0;
        idle(10);
        @(negedge clk);
        check("glitch_busy_mid", busy, 1'b1);
        idle(10);
        #1 ser = 1'b1;
        idle(20);
        @(negedge clk);
        check("glitch_busy_40", busy, 1'b0);
        idle(700);
        @(negedge clk);
        check("glitch_pulses", q_dat.size(), 0);
        check("glitch_rx_data", rx_data, 8'hA5);

        // Framing error on 0x3C followed by a 200-clk break, then 0x5A
        clear_log();
        send_frame(8'h3C, 1'b0, 1'b0, FRAME_BITS, t0);
        @(negedge clk);
        check("ferr_flag", ferr, 1'b1);
        check("ferr_pulses", q_dat.size(), 0);
        idle(200);
        @(negedge clk);
        check("ferr_wait_high_busy", busy, 1'b1);
        check("ferr_rx_data", rx_data, 8'hA5);
        @(posedge clk);
        #1 ser = 1'b1;
        idle(10);
        @(negedge clk);
        check("ferr_busy_released", busy, 1'b0);
        clear_log();
        send_frame(8'h5A, 1'b0, 1'b1, FRAME_BITS, t0);
        idle(20);
        @(negedge clk);
        check("after_ferr_pulses", q_dat.size(), 1);
        check("after_ferr_data", dat_at(0), 8'h5A);
        check("after_ferr_flag", ferr, 1'b0);
        check("after_ferr_parity", perr, 1'b0);

        // Back-to-back 0x00 then 0xFF with no idle between frames
        clear_log();
        send_frame(8'h00, 1'b0, 1'b1, FRAME_BITS, t0);
        send_frame(8'hFF, 1'b0, 1'b1, FRAME_BITS, t1);
        idle(20);
        @(negedge clk);
        check("b2b_pulses", q_dat.size(), 2);
        check("b2b_first", dat_at(0), 8'h00);
        check("b2b_second", dat_at(1), 8'hFF);
        check("b2b_spacing", cyc_at(1) - cyc_at(0), FRAME_BITS * BIT_CLKS);

        // Reset mid-bit-4 of 0x81; the transmitter side also drops back to idle
        clear_log();
        send_frame(8'h81, 1'b0, 1'b1, 5, t0);
        @(posedge clk);
        #1 ser = 1'b0;
        idle(31);
        @(negedge clk);
        check("midrst_busy_before", busy, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ser = 1'b1;
        @(negedge clk);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_data_rdy", data_rdy, 1'b0);
        check("midrst_framing_err", ferr, 1'b0);
        check("midrst_parity_err", perr, 1'b0);
        check("midrst_busy", busy, 1'b0);
        idle(700);
        @(negedge clk);
        check("midrst_pulses", q_dat.size(), 0);
        clear_log();
        send_frame(8'h81, 1'b0, 1'b1, FRAME_BITS, t0);
        idle(20);
        @(negedge clk);
        check("post_rst_pulses", q_dat.size(), 1);
        check("post_rst_data", dat_at(0), 8'h81);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x01 needs a parity bit of 1
        clear_log();
        send_frame(8'h01, 1'b0, 1'b1, FRAME_BITS, t0);
        idle(20);
        @(negedge clk);
        check("par_bad_flag", perr, 1'b1);
        check("par_bad_pulses", q_dat.size(), 0);
        check("par_bad_rx_data", rx_data, 8'h81);
        clear_log();
        send_frame(8'h01, 1'b1, 1'b1, FRAME_BITS, t0);
        idle(20);
        @(negedge clk);
        check("par_ok_flag", perr, 1'b0);
        check("par_ok_pulses", q_dat.size(), 1);
        check("par_ok_data", dat_at(0), 8'h01);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
